// File: rtl/mul_acc32_pkg.sv
// Shared definitions for the iterative multiply-accumulate reconstruction block.
package mul_acc32_pkg;

  localparam int W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/mac_step.sv
// One radix-2 shift-add step: adds the shifted multiplicand when the multiplier bit is set.
module mac_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic           mbit,
  output logic [2*W-1:0] acc_nxt
);

  assign acc_nxt = acc + (mbit ? mcand : '0);

endmodule

// File: rtl/mul_acc32.sv
// Iterative x = q*d + r reconstruction: the accumulator starts at r and retires one bit of q per cycle.
module mul_acc32
  import mul_acc32_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] x,
  output logic           rem_invalid
);

  localparam int CW = cnt_width(W);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mplier;
  logic           rem_bad;

  mac_step #(.W(W)) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .mbit    (mplier[0]),
    .acc_nxt (acc_nxt)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem_bad     <= 1'b0;
      x           <= '0;
      rem_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= {{W{1'b0}}, r};
            mcand   <= {{W{1'b0}}, d};
            mplier  <= q;
            rem_bad <= (r >= d);
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // LSB-first: the multiplicand doubles each step to match the weight of the next q bit
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            x           <= acc_nxt;
            rem_invalid <= rem_bad;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_acc32.md
MUL_ACC32 -- requirements
Module: mul_acc32

Interface
REQ-001 The module SHALL have one parameter, W, default 32, giving the operand width; the result width is 2*W.
REQ-002 Port clk: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port rstn: input, 1 bit, asynchronous active-low reset.
REQ-004 Port in_valid: input, 1 bit, operands present.
REQ-005 Port in_ready: output, 1 bit, block can accept operands.
REQ-006 Port q: input, W bits, unsigned quotient operand.
REQ-007 Port d: input, W bits, unsigned divisor operand.
REQ-008 Port r: input, W bits, unsigned remainder operand.
REQ-009 Port out_valid: output, 1 bit, result present.
REQ-010 Port out_ready: input, 1 bit, consumer accepts the result.
REQ-011 Port x: output, 2W bits, reconstructed dividend, equal to q*d + r.
REQ-012 Port rem_invalid: output, 1 bit, set when r >= d, meaning (q, r) is not a canonical division result.

Function
REQ-013 The module SHALL compute x = q*d + r exactly, unsigned; the maximum value (2^W-1)^2 + 2^W-1 fits in 2W bits, so no overflow exists.
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE, and the encoding SHALL come from the shared package.
REQ-015 in_ready SHALL be 1 if and only if the state is IDLE; out_valid SHALL be 1 if and only if the state is DONE.
REQ-016 An accept occurs on a rising edge where in_valid & in_ready; at that edge q, d and r SHALL be registered, the accumulator SHALL be loaded with r, the iteration counter SHALL be cleared, and the state SHALL become BUSY.
REQ-017 In BUSY, each edge SHALL retire exactly one multiplier bit of q (shift-add, radix-2), for exactly W edges.
REQ-018 On the W-th BUSY edge, the state SHALL become DONE, and x and rem_invalid SHALL become valid at that edge.
REQ-019 Latency: for an accept at edge E0, out_valid SHALL first be 1 after edge E0+W (E0+32 at the default W).
REQ-020 In DONE, x and rem_invalid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-021 In DONE, an edge with out_ready=1 SHALL return the state to IDLE, and out_valid SHALL drop after that edge.
REQ-022 The module SHALL NOT accept new operands in the same cycle as the output handshake; the earliest next accept is the edge after the return to IDLE.
REQ-023 in_valid, q, d and r SHALL be ignored in BUSY and DONE, and operand changes after the accept SHALL NOT affect the result.
REQ-024 d=0 SHALL give x=r and rem_invalid=1.
REQ-025 q=0 SHALL give x=r.
REQ-026 x SHALL hold its last value in IDLE (0 after reset).

Reset
REQ-027 While rstn=0, the state SHALL be IDLE, in_ready=1, out_valid=0, x=0, rem_invalid=0, and the counter and accumulator SHALL be 0.
REQ-028 Reset asserted in any state, including mid-BUSY, SHALL abort the operation immediately and produce no output.
REQ-029 After reset release, the first rising edge SHALL be able to accept an operation.

Structure
REQ-030 Shared package mul_acc32_pkg SHALL hold the default W, the state enum, and the counter width $clog2(W)+1.
REQ-031 One sub-module SHALL exist: mac_step, a combinational single-bit shift-add step (accumulator, multiplicand, multiplier bit in; next accumulator out), instanced once.
REQ-032 The datapath SHALL be iterative (one mac_step); no full-array multiplier SHALL be used.

Verification
REQ-033 The bench SHALL drive q=3, d=5, r=2 -> required: x=17, rem_invalid=0, out_valid rising exactly 32 edges after the accept.
REQ-034 The bench SHALL drive q=d=0xFFFFFFFF, r=0xFFFFFFFE -> required: x=0xFFFFFFFEFFFFFFFF, rem_invalid=0.
REQ-035 The bench SHALL drive q=7, d=0, r=9 -> required: x=9, rem_invalid=1.
REQ-036 The bench SHALL hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands -> required: x and rem_invalid constant, in_ready=0, no second accept.
REQ-037 The bench SHALL assert rstn=0 at BUSY iteration 10, then release and drive q=2, d=4, r=1 -> required: no out_valid from the aborted operation, then x=9.
REQ-038 The bench SHALL run 1000 random (q, d, r) sets with random out_ready backpressure -> required: every x matches a reference model q*d+r and rem_invalid matches (r>=d).
